// File: rtl/tx_fifo.sv
// -----------------------------------------------------------------------------
// tx_fifo
//
// Transmit FIFO between the APB bridge (producer) and the I2C core (consumer).
// DEPTH = 2**AWIDTH words of DWIDTH bits. A pop presents the oldest word on
// DATA_OUT one edge later, and DATA_OUT holds until the next accepted pop.
// Overflow and underflow attempts are latched in sticky flags until CLEAR_ERR.
//
// Ports
//   PCLK              clock, rising edge
//   PRESETn           asynchronous active-low reset
//   WR_ENA            push request, one cycle per word
//   WRITE_DATA_ON_TX  word to push, sampled with WR_ENA
//   RD_ENA_TX         pop request
//   CLEAR_ERR         synchronous clear of OVERFLOW / UNDERFLOW
//   DATA_OUT          registered popped word
//   TX_EMPTY          LEVEL == 0
//   TX_FULL           LEVEL == DEPTH
//   LEVEL             number of stored words, 0..DEPTH
//   OVERFLOW          sticky: push rejected because full
//   UNDERFLOW         sticky: pop attempted while empty
//   ERROR             OVERFLOW | UNDERFLOW
// -----------------------------------------------------------------------------
module tx_fifo #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 4
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              WR_ENA,
    input  logic [DWIDTH-1:0] WRITE_DATA_ON_TX,
    input  logic              RD_ENA_TX,
    input  logic              CLEAR_ERR,
    output logic [DWIDTH-1:0] DATA_OUT,
    output logic              TX_EMPTY,
    output logic              TX_FULL,
    output logic [AWIDTH:0]   LEVEL,
    output logic              OVERFLOW,
    output logic              UNDERFLOW,
    output logic              ERROR
);

    localparam int DEPTH = 1 << AWIDTH;
    // DEPTH expressed in LEVEL's width: only the MSB set.
    localparam logic [AWIDTH:0] LEVEL_FULL = {1'b1, {AWIDTH{1'b0}}};

    // Storage is deliberately not reset; stale contents are unreachable
    // because the pointers and LEVEL are reset.
    logic [DWIDTH-1:0] mem [DEPTH];

    logic [AWIDTH-1:0] wp_reg, wp_next;
    logic [AWIDTH-1:0] rp_reg, rp_next;
    logic [AWIDTH:0]   level_reg, level_next;
    logic [DWIDTH-1:0] dout_reg, dout_next;
    logic              overflow_reg, overflow_next;
    logic              underflow_reg, underflow_next;

    logic              push_accept;
    logic              pop_accept;
    logic              overflow_event;
    logic              underflow_event;
    logic [DEPTH-1:0]  word_we;

    // Flags are decoded from the registered LEVEL, so they follow the
    // causing edge by one cycle.
    assign TX_EMPTY = (level_reg == '0);
    assign TX_FULL  = (level_reg == LEVEL_FULL);

    // A push into a full FIFO is still accepted when a pop frees a slot on
    // the same edge. A pop on an empty FIFO is never accepted, even if a
    // push arrives at the same time (the new word is not bypassed).
    assign push_accept     = WR_ENA & (~TX_FULL | RD_ENA_TX);
    assign pop_accept      = RD_ENA_TX & ~TX_EMPTY;
    assign overflow_event  = WR_ENA & TX_FULL & ~RD_ENA_TX;
    assign underflow_event = RD_ENA_TX & TX_EMPTY;

    // One write enable per storage word.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word_we
            assign word_we[gi] = push_accept & (wp_reg == AWIDTH'(gi));
        end
    endgenerate

    always_ff @(posedge PCLK) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (word_we[i]) begin
                mem[i] <= WRITE_DATA_ON_TX;
            end
        end
    end

    always_comb begin
        wp_next        = wp_reg;
        rp_next        = rp_reg;
        level_next     = level_reg;
        dout_next      = dout_reg;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;

        // Pointers wrap naturally through their AWIDTH-bit width.
        if (push_accept) begin
            wp_next = wp_reg + 1'b1;
        end
        // When full with push and pop together wp == rp; the read here sees
        // the pre-edge contents, so the oldest word is returned, not the new one.
        if (pop_accept) begin
            rp_next   = rp_reg + 1'b1;
            dout_next = mem[rp_reg];
        end

        case ({push_accept, pop_accept})
            2'b10:   level_next = level_reg + 1'b1;
            2'b01:   level_next = level_reg - 1'b1;
            default: level_next = level_reg;
        endcase

        // A new error on a clear cycle wins over the clear.
        if (CLEAR_ERR) begin
            overflow_next  = 1'b0;
            underflow_next = 1'b0;
        end
        if (overflow_event) begin
            overflow_next = 1'b1;
        end
        if (underflow_event) begin
            underflow_next = 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wp_reg        <= '0;
            rp_reg        <= '0;
            level_reg     <= '0;
            dout_reg      <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wp_reg        <= wp_next;
            rp_reg        <= rp_next;
            level_reg     <= level_next;
            dout_reg      <= dout_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    assign DATA_OUT  = dout_reg;
    assign LEVEL     = level_reg;
    assign OVERFLOW  = overflow_reg;
    assign UNDERFLOW = underflow_reg;
    assign ERROR     = overflow_reg | underflow_reg;

endmodule

// File: tb/tb_tx_fifo.sv
module tb_tx_fifo;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          WR_ENA;
    logic [DW-1:0] WRITE_DATA_ON_TX;
    logic          RD_ENA_TX;
    logic          CLEAR_ERR;
    logic [DW-1:0] DATA_OUT;
    logic          TX_EMPTY;
    logic          TX_FULL;
    logic [AW:0]   LEVEL;
    logic          OVERFLOW;
    logic          UNDERFLOW;
    logic          ERROR;

    int checks = 0;
    int passes = 0;

    // Reference model and scoreboard.
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_q[$];
    bit            m_of;
    bit            m_uf;
    bit            last_ra;
    logic [DW-1:0] m_dout;

    tx_fifo #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .PCLK             (PCLK),
        .PRESETn          (PRESETn),
        .WR_ENA           (WR_ENA),
        .WRITE_DATA_ON_TX (WRITE_DATA_ON_TX),
        .RD_ENA_TX        (RD_ENA_TX),
        .CLEAR_ERR        (CLEAR_ERR),
        .DATA_OUT         (DATA_OUT),
        .TX_EMPTY         (TX_EMPTY),
        .TX_FULL          (TX_FULL),
        .LEVEL            (LEVEL),
        .OVERFLOW         (OVERFLOW),
        .UNDERFLOW        (UNDERFLOW),
        .ERROR            (ERROR)
    );

    always #5 PCLK = ~PCLK;

    task automatic reset_model();
        model_q.delete();
        exp_q.delete();
        m_of    = 1'b0;
        m_uf    = 1'b0;
        last_ra = 1'b0;
        m_dout  = '0;
    endtask

    // Drive one cycle; the model is advanced from its pre-edge state and any
    // word the DUT should pop is pushed onto exp_q. Returns at posedge + 1.
    task automatic drive(input bit wr, input logic [DW-1:0] d, input bit rd, input bit clr);
        bit m_full;
        bit m_empty;
        bit pa;
        m_full  = (model_q.size() == DEPTH);
        m_empty = (model_q.size() == 0);
        pa      = wr && (!m_full || rd);
        last_ra = rd && !m_empty;
        if (clr) begin
            m_of = 1'b0;
            m_uf = 1'b0;
        end
        if (wr && m_full && !rd) m_of = 1'b1;
        if (rd && m_empty)       m_uf = 1'b1;
        if (last_ra) begin
            m_dout = model_q.pop_front();
            exp_q.push_back(m_dout);
        end
        if (pa) model_q.push_back(d);
        WR_ENA           = wr;
        WRITE_DATA_ON_TX = d;
        RD_ENA_TX        = rd;
        CLEAR_ERR        = clr;
        @(posedge PCLK);
        #1;
        WR_ENA           = 1'b0;
        WRITE_DATA_ON_TX = '0;
        RD_ENA_TX        = 1'b0;
        CLEAR_ERR        = 1'b0;
        $display("txn wr=%0b d=%0h rd=%0b clr=%0b -> level=%0d dout=%0h of=%0b uf=%0b",
                 wr, d, rd, clr, LEVEL, DATA_OUT, OVERFLOW, UNDERFLOW);
    endtask

    task automatic test_reset();
        PRESETn          = 1'b0;
        WR_ENA           = 1'b1;
        RD_ENA_TX        = 1'b1;
        CLEAR_ERR        = 1'b0;
        WRITE_DATA_ON_TX = 32'hDEAD_BEEF;
        reset_model();
        repeat (2) @(posedge PCLK);
        #1;
        checks++; if (LEVEL !== '0)    $display("FAIL reset_level: got %0d expected 0", LEVEL); else passes++;
        checks++; if (TX_EMPTY !== 1'b1) $display("FAIL reset_empty: got %0b expected 1", TX_EMPTY); else passes++;
        checks++; if (TX_FULL !== 1'b0)  $display("FAIL reset_full: got %0b expected 0", TX_FULL); else passes++;
        checks++; if (DATA_OUT !== '0)   $display("FAIL reset_dout: got %0h expected 0", DATA_OUT); else passes++;
        checks++; if ({OVERFLOW, UNDERFLOW, ERROR} !== 3'b000)
            $display("FAIL reset_flags: got %b expected 000", {OVERFLOW, UNDERFLOW, ERROR}); else passes++;
        @(negedge PCLK);
        WR_ENA    = 1'b0;
        RD_ENA_TX = 1'b0;
        WRITE_DATA_ON_TX = '0;
        PRESETn   = 1'b1;
        // First push after release must be honoured.
        drive(1'b1, 32'h77, 1'b0, 1'b0);
        checks++; if (LEVEL !== 5'd1) $display("FAIL reset_first_push: got %0d expected 1", LEVEL); else passes++;
        drive(1'b0, '0, 1'b1, 1'b0);
        checks++; if (DATA_OUT !== 32'h77) $display("FAIL reset_first_pop: got %0h expected 77", DATA_OUT); else passes++;
        void'(exp_q.pop_front());
    endtask

    task automatic test_basic();
        logic [DW-1:0] w;
        logic [DW-1:0] vals [3];
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, vals[i], 1'b0, 1'b0);
            checks++; if (LEVEL !== 5'(i + 1)) $display("FAIL basic_push_level: got %0d expected %0d", LEVEL, i + 1); else passes++;
        end
        for (int i = 0; i < 3; i++) begin
            checks++; if (TX_EMPTY !== 1'b0) $display("FAIL basic_not_empty: got %0b expected 0", TX_EMPTY); else passes++;
            drive(1'b0, '0, 1'b1, 1'b0);
            w = exp_q.pop_front();
            checks++; if (DATA_OUT !== w || DATA_OUT !== vals[i])
                $display("FAIL basic_pop_data: got %0h expected %0h", DATA_OUT, vals[i]); else passes++;
            checks++; if (LEVEL !== 5'(2 - i)) $display("FAIL basic_pop_level: got %0d expected %0d", LEVEL, 2 - i); else passes++;
        end
        checks++; if (TX_EMPTY !== 1'b1) $display("FAIL basic_empty_after: got %0b expected 1", TX_EMPTY); else passes++;
    endtask

    task automatic test_overflow();
        logic [DW-1:0] w;
        for (int i = 0; i < DEPTH; i++) drive(1'b1, DW'(i), 1'b0, 1'b0);
        checks++; if (TX_FULL !== 1'b1) $display("FAIL ovf_full: got %0b expected 1", TX_FULL); else passes++;
        checks++; if (LEVEL !== 5'd16)  $display("FAIL ovf_level16: got %0d expected 16", LEVEL); else passes++;
        drive(1'b1, 32'hAA, 1'b0, 1'b0);
        checks++; if (OVERFLOW !== 1'b1 || ERROR !== 1'b1)
            $display("FAIL ovf_flag: got of=%0b err=%0b expected 1 1", OVERFLOW, ERROR); else passes++;
        checks++; if (LEVEL !== 5'd16) $display("FAIL ovf_level_hold: got %0d expected 16", LEVEL); else passes++;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            w = exp_q.pop_front();
            checks++; if (DATA_OUT !== w || DATA_OUT !== DW'(i))
                $display("FAIL ovf_pop_data: got %0h expected %0h", DATA_OUT, i); else passes++;
        end
        checks++; if (OVERFLOW !== 1'b1) $display("FAIL ovf_sticky: got %0b expected 1", OVERFLOW); else passes++;
        drive(1'b0, '0, 1'b0, 1'b1);
        checks++; if (ERROR !== 1'b0) $display("FAIL ovf_clear: got %0b expected 0", ERROR); else passes++;
    endtask

    task automatic test_full_simul();
        logic [DW-1:0] w;
        for (int i = 0; i < DEPTH; i++) drive(1'b1, DW'(32'h40 + i), 1'b0, 1'b0);
        drive(1'b1, 32'h99, 1'b1, 1'b0);
        w = exp_q.pop_front();
        checks++; if (DATA_OUT !== w || DATA_OUT !== 32'h40)
            $display("FAIL fullrw_data: got %0h expected 40", DATA_OUT); else passes++;
        checks++; if (LEVEL !== 5'd16) $display("FAIL fullrw_level: got %0d expected 16", LEVEL); else passes++;
        checks++; if (OVERFLOW !== 1'b0) $display("FAIL fullrw_no_ovf: got %0b expected 0", OVERFLOW); else passes++;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            w = exp_q.pop_front();
            checks++; if (DATA_OUT !== w) $display("FAIL fullrw_drain: got %0h expected %0h", DATA_OUT, w); else passes++;
        end
        checks++; if (DATA_OUT !== 32'h99) $display("FAIL fullrw_last: got %0h expected 99", DATA_OUT); else passes++;
    endtask

    task automatic test_empty_simul();
        logic [DW-1:0] w;
        drive(1'b1, 32'h5, 1'b1, 1'b0);
        checks++; if (UNDERFLOW !== 1'b1) $display("FAIL emptyrw_uf: got %0b expected 1", UNDERFLOW); else passes++;
        checks++; if (LEVEL !== 5'd1) $display("FAIL emptyrw_level: got %0d expected 1", LEVEL); else passes++;
        checks++; if (DATA_OUT !== m_dout) $display("FAIL emptyrw_hold: got %0h expected %0h", DATA_OUT, m_dout); else passes++;
        drive(1'b0, '0, 1'b1, 1'b0);
        w = exp_q.pop_front();
        checks++; if (DATA_OUT !== w || DATA_OUT !== 32'h5)
            $display("FAIL emptyrw_pop: got %0h expected 5", DATA_OUT); else passes++;
        drive(1'b0, '0, 1'b0, 1'b1);
        checks++; if (ERROR !== 1'b0) $display("FAIL emptyrw_clear: got %0b expected 0", ERROR); else passes++;
        // Clear and a fresh underflow on the same edge: the error wins.
        drive(1'b0, '0, 1'b1, 1'b1);
        checks++; if (UNDERFLOW !== m_uf || UNDERFLOW !== 1'b1)
            $display("FAIL clear_vs_err: got %0b expected 1", UNDERFLOW); else passes++;
        drive(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_wrap();
        logic [DW-1:0] w;
        bit wr;
        bit rd;
        for (int i = 0; i < 40; i++) begin
            if (i < 20) begin
                wr = ($urandom_range(0, 3) != 0);
                rd = ($urandom_range(0, 1) == 1);
            end else begin
                wr = ($urandom_range(0, 3) == 0);
                rd = ($urandom_range(0, 3) != 0);
            end
            drive(wr, DW'($urandom), rd, 1'b0);
            if (last_ra) begin
                w = exp_q.pop_front();
                checks++; if (DATA_OUT !== w) $display("FAIL wrap_data: got %0h expected %0h", DATA_OUT, w); else passes++;
            end else begin
                checks++; if (DATA_OUT !== m_dout) $display("FAIL wrap_hold: got %0h expected %0h", DATA_OUT, m_dout); else passes++;
            end
            checks++; if (LEVEL !== 5'(model_q.size()))
                $display("FAIL wrap_level: got %0d expected %0d", LEVEL, model_q.size()); else passes++;
            checks++; if ({OVERFLOW, UNDERFLOW} !== {m_of, m_uf})
                $display("FAIL wrap_flags: got %b expected %b", {OVERFLOW, UNDERFLOW}, {m_of, m_uf}); else passes++;
        end
        while (model_q.size() > 0) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            w = exp_q.pop_front();
            checks++; if (DATA_OUT !== w) $display("FAIL wrap_drain: got %0h expected %0h", DATA_OUT, w); else passes++;
        end
        drive(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 8; i++) drive(1'b1, DW'(32'hC0 + i), 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        void'(exp_q.pop_front());
        checks++; if (LEVEL !== 5'd7) $display("FAIL arst_pre_level: got %0d expected 7", LEVEL); else passes++;
        // Assert reset mid-cycle, well away from any rising edge.
        #3;
        PRESETn = 1'b0;
        #1;
        checks++; if (LEVEL !== '0 || TX_EMPTY !== 1'b1 || TX_FULL !== 1'b0)
            $display("FAIL arst_level: got level=%0d e=%0b f=%0b expected 0 1 0", LEVEL, TX_EMPTY, TX_FULL); else passes++;
        checks++; if (DATA_OUT !== '0) $display("FAIL arst_dout: got %0h expected 0", DATA_OUT); else passes++;
        checks++; if ({OVERFLOW, UNDERFLOW, ERROR} !== 3'b000)
            $display("FAIL arst_flags: got %b expected 000", {OVERFLOW, UNDERFLOW, ERROR}); else passes++;
        @(negedge PCLK);
        PRESETn = 1'b1;
        reset_model();
        drive(1'b0, '0, 1'b1, 1'b0);
        checks++; if (UNDERFLOW !== 1'b1 || LEVEL !== '0)
            $display("FAIL arst_post_pop: got uf=%0b level=%0d expected 1 0", UNDERFLOW, LEVEL); else passes++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_simul();
        test_empty_simul();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/tx_fifo.md
TX_FIFO -- requirements
Module: tx_fifo

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 32, data word width in bits.
REQ-002 The block SHALL have parameter AWIDTH, default 4, pointer width; depth DEPTH = 2^AWIDTH (16 by default).
REQ-003 PCLK  input  1  clock; all state SHALL change on the rising edge only.
REQ-004 PRESETn  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-005 WR_ENA  input  1  push request from the APB bridge, one cycle per transfer.
REQ-006 WRITE_DATA_ON_TX  input  DWIDTH  word to push, sampled with WR_ENA.
REQ-007 RD_ENA_TX  input  1  pop request from the I2C core.
REQ-008 CLEAR_ERR  input  1  synchronous clear of the sticky error flags.
REQ-009 DATA_OUT  output  DWIDTH  registered popped word.
REQ-010 TX_EMPTY  output  1  high when LEVEL == 0.
REQ-011 TX_FULL  output  1  high when LEVEL == DEPTH.
REQ-012 LEVEL  output  AWIDTH+1  number of stored words, 0..DEPTH.
REQ-013 OVERFLOW  output  1  sticky; push attempted and rejected.
REQ-014 UNDERFLOW  output  1  sticky; pop attempted while empty.
REQ-015 ERROR  output  1  OVERFLOW | UNDERFLOW, combinational.

Function
REQ-016 Storage SHALL be DEPTH x DWIDTH registers, addressed by write pointer WP and read pointer RP, each AWIDTH bits.
REQ-017 Push accepted (PA) SHALL = WR_ENA & (!TX_FULL | RD_ENA_TX); on PA, mem[WP] <= WRITE_DATA_ON_TX and WP <= WP+1.
REQ-018 Pop accepted (RA) SHALL = RD_ENA_TX & !TX_EMPTY; on RA, DATA_OUT <= mem[RP] and RP <= RP+1.
REQ-019 Pointers SHALL wrap modulo DEPTH (15 -> 0) with no other side effect.
REQ-020 Pop latency SHALL be one cycle: DATA_OUT shows the popped word from the edge where RA is true until the next RA.
REQ-021 DATA_OUT SHALL hold its value on cycles without RA, including rejected pops.
REQ-022 LEVEL SHALL update on the same edge: +1 on PA only, -1 on RA only, unchanged when both or neither.
REQ-023 TX_EMPTY and TX_FULL SHALL be decoded from the registered LEVEL, so they change in the cycle after the causing edge.
REQ-024 Full with push and pop in the same cycle: both SHALL be accepted; DATA_OUT gets the oldest word, not the new one; LEVEL stays at DEPTH.
REQ-025 Empty with push and pop in the same cycle: the push SHALL be accepted; the pop SHALL be rejected, UNDERFLOW SHALL set and LEVEL SHALL become 1.
REQ-026 OVERFLOW SHALL set on an edge with WR_ENA & TX_FULL & !RD_ENA_TX; the data SHALL be discarded and WP/LEVEL unchanged.
REQ-027 UNDERFLOW SHALL set on an edge with RD_ENA_TX & TX_EMPTY.
REQ-028 OVERFLOW and UNDERFLOW SHALL stay set until CLEAR_ERR or reset; a new error on a CLEAR_ERR cycle SHALL win, and the flag stays set.
REQ-029 Pushed data SHALL never be reordered, duplicated or dropped except under REQ-026.

Reset
REQ-030 On PRESETn low, asynchronously: WP = RP = 0, LEVEL = 0, TX_EMPTY = 1, TX_FULL = 0, DATA_OUT = 0, OVERFLOW = UNDERFLOW = ERROR = 0.
REQ-031 Storage contents SHALL NOT be reset; reset during traffic SHALL discard all stored words immediately.
REQ-032 WR_ENA and RD_ENA_TX SHALL be ignored while PRESETn is low; the first push or pop SHALL be honoured on the first rising edge with PRESETn high.

Verification
REQ-033 Push 0x11,0x22,0x33, then 3 pops -> DATA_OUT = 0x11,0x22,0x33 one cycle after each pop; LEVEL 3->0; TX_EMPTY rises after the last pop.
REQ-034 Push 16 words 0..15 -> TX_FULL=1, LEVEL=16; 17th push 0xAA -> OVERFLOW=1, ERROR=1, LEVEL=16; 16 pops return 0..15 with no 0xAA.
REQ-035 Fill FIFO, then push 0x99 and pop in the same cycle -> DATA_OUT = first word, LEVEL=16, OVERFLOW=0; after 16 more pops, the last value is 0x99.
REQ-036 Empty FIFO, push 0x5 and pop in the same cycle -> UNDERFLOW=1, LEVEL=1; next pop -> DATA_OUT = 0x5; CLEAR_ERR pulse -> ERROR=0.
REQ-037 Run 40 pushes and pops interleaved across the pointer wrap -> in-order data; LEVEL matches the model every cycle.
REQ-038 Assert PRESETn low mid-clock with LEVEL=7 -> all outputs at reset values before the next edge; a pop after release -> UNDERFLOW=1.
